cv32e40p_ex_wb_pipeline: RTL

CV32E40P_EX_WB_PIPELINE -- requirements
Module: cv32e40p_ex_wb_pipeline

---
 rtl/cv32e40p_pkg.sv | 12 +
 rtl/cv32e40p_parity_gen.sv | 12 +
 rtl/cv32e40p_ex_wb_pipeline.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the EX->WB load write-back path.
package cv32e40p_pkg;

  // Load write-back tracking: waiting for the first half of a misaligned
  // load, waiting for the final (or only) response, or idle.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    WAIT_LAST  = 2'd2
  } ex_wb_state_e;

endpackage

// File: rtl/cv32e40p_parity_gen.sv
// Even-parity generator: o_parity makes the total count of ones in
// {i_data, o_parity} even.
module cv32e40p_parity_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  assign o_parity = ^i_data;

endmodule

// File: rtl/cv32e40p_ex_wb_pipeline.sv
// EX->WB load write-back stage. Tracks one outstanding load (one or two
// LSU responses) and strobes the register-file write one cycle after the
// final response. A new load may be accepted on the final-response cycle.
// Optional feature macro: CV32E40P_FT_WB_PARITY_EN adds parity protection
// of the pending address and the write data, reported on ft_err_o.
module cv32e40p_ex_wb_pipeline
  import cv32e40p_pkg::*;
#(
  parameter int REGADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid_i,
  input  logic                 regfile_we_ex_i,
  input  logic [REGADDR_W-1:0] regfile_waddr_ex_i,
  input  logic                 data_req_ex_i,
  input  logic                 data_we_ex_i,
  input  logic                 data_misaligned_ex_i,
  input  logic                 lsu_rvalid_i,
  input  logic [31:0]          lsu_rdata_i,
  output logic                 wb_ready_o,
  output logic                 regfile_we_wb_o,
  output logic [REGADDR_W-1:0] regfile_waddr_wb_o,
  output logic [31:0]          regfile_wdata_wb_o,
  output logic                 ft_err_o
);

  ex_wb_state_e         r_state;
  ex_wb_state_e         w_state_nxt;
  logic                 w_load;
  logic                 w_last;
  logic [REGADDR_W-1:0] r_pend_addr;
  logic                 r_we;
  logic [REGADDR_W-1:0] r_waddr;
  logic [31:0]          r_wdata;

  // Final response of the outstanding load arrives this cycle.
  assign w_last     = (r_state == WAIT_LAST) && lsu_rvalid_i;
  assign wb_ready_o = (r_state == IDLE) || w_last;
  assign w_load     = ex_valid_i & wb_ready_o & data_req_ex_i &
                      ~data_we_ex_i & regfile_we_ex_i;

  // Next-state: response progress first, a newly accepted load overrides
  // so that a load taken on the final-response cycle starts without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_FIRST: if (lsu_rvalid_i) w_state_nxt = WAIT_LAST;
      WAIT_LAST:  if (lsu_rvalid_i) w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
    if (w_load) begin
      w_state_nxt = data_misaligned_ex_i ? WAIT_FIRST : WAIT_LAST;
    end
  end

  // State, pending address and write-back registers. The pending address is
  // separate from the write address so a load latched on the final-response
  // cycle cannot corrupt the address being strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend_addr <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_last;
      if (w_load) begin
        r_pend_addr <= regfile_waddr_ex_i;
      end
      if (w_last) begin
        r_waddr <= r_pend_addr;
        r_wdata <= lsu_rdata_i;
      end
    end
  end

  assign regfile_we_wb_o    = r_we;
  assign regfile_waddr_wb_o = r_waddr;
  assign regfile_wdata_wb_o = r_wdata;

`ifdef CV32E40P_FT_WB_PARITY_EN
  logic r_pend_par;
  logic r_wdata_par;
  logic r_ft_err;
  logic w_par_addr_in;
  logic w_par_data_in;
  logic w_par_addr_chk;
  logic w_par_data_chk;

  cv32e40p_parity_gen #(.WIDTH(REGADDR_W)) u_par_addr_in (
    .i_data   (regfile_waddr_ex_i),
    .o_parity (w_par_addr_in)
  );

  cv32e40p_parity_gen #(.WIDTH(32)) u_par_data_in (
    .i_data   (lsu_rdata_i),
    .o_parity (w_par_data_in)
  );

  cv32e40p_parity_gen #(.WIDTH(REGADDR_W)) u_par_addr_chk (
    .i_data   (r_pend_addr),
    .o_parity (w_par_addr_chk)
  );

  cv32e40p_parity_gen #(.WIDTH(32)) u_par_data_chk (
    .i_data   (r_wdata),
    .o_parity (w_par_data_chk)
  );

  // Store parity with each protected register and recheck it every cycle;
  // any mismatch latches a sticky error until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_par  <= 1'b0;
      r_wdata_par <= 1'b0;
      r_ft_err    <= 1'b0;
    end else begin
      if (w_load) begin
        r_pend_par <= w_par_addr_in;
      end
      if (w_last) begin
        r_wdata_par <= w_par_data_in;
      end
      if ((w_par_addr_chk != r_pend_par) || (w_par_data_chk != r_wdata_par)) begin
        r_ft_err <= 1'b1;
      end
    end
  end

  assign ft_err_o = r_ft_err;
`else
  assign ft_err_o = 1'b0;
`endif

endmodule
